// File: rtl/minisys_pkg.sv
// Shared encodings for the MiniSys-1A memory stage: load types, store sizes
// and the MEM-stage bus FSM state.
package minisys_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_B    = 4'b0001;
  localparam logic [3:0] ST_H    = 4'b0011;
  localparam logic [3:0] ST_W    = 4'b1111;

  typedef logic [0:0] memState_t;
  localparam memState_t S_IDLE = 1'b0;
  localparam memState_t S_WAIT = 1'b1;

  // A store's own size wins over the load type when both are present.
  function automatic logic isMisaligned(input logic [3:0] memwrite,
                                        input logic [2:0] ldtype,
                                        input logic [1:0] a);
    logic half;
    logic word;
    if (memwrite != ST_NONE) begin
      half = (memwrite == ST_H);
      word = (memwrite == ST_W);
    end else begin
      half = (ldtype == LD_H) || (ldtype == LD_HU);
      word = !((ldtype == LD_B) || (ldtype == LD_BU) || half);
    end
    return (half & a[0]) | (word & (a != 2'b00));
  endfunction

endpackage

// File: rtl/minisys_load_align.sv
// Extracts and extends the addressed byte/halfword of a little-endian read
// word; purely combinational so the WB forwarding path can reuse it.
module minisys_load_align
  import minisys_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  ldtype,
  input  logic [1:0]  a,
  output logic [31:0] data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdata[7:0];
    case (a)
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      2'd3:    byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
    halfSel = a[1] ? rdata[31:16] : rdata[15:0];

    case (ldtype)
      LD_B:    data = {{24{byteSel[7]}}, byteSel};
      LD_BU:   data = {24'd0, byteSel};
      LD_H:    data = {{16{halfSel[15]}}, halfSel};
      LD_HU:   data = {16'd0, halfSel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/minisys_mem_stage.sv
// MiniSys-1A MEM stage: data-memory access over a req/ready bus with
// timeout, branch resolution, and the MEM/WB pipeline register.
module minisys_mem_stage
  import minisys_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        regwriteM,
  input  logic        mem2regM,
  input  logic        branchM,
  input  logic        zeroM,
  input  logic [3:0]  memwriteM,
  input  logic [2:0]  ldtypeM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  input  logic [4:0]  write_regM,
  input  logic [31:0] pc_branchM,
  output logic        pcsrcM,
  output logic [31:0] pc_branch_o,
  output logic        stallM,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        regwriteW,
  output logic        mem2regW,
  output logic [31:0] read_dataW,
  output logic [31:0] alu_outW,
  output logic [4:0]  write_regW,
  output logic        misalignW,
  output logic        bus_errW
);

  memState_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         a;
  logic               isStore;
  logic               acc;
  logic               misal;
  logic               accOk;
  logic               timeoutHit;
  logic               done;
  logic               loadDone;
  logic [31:0]        loadData;

  assign a           = alu_outM[1:0];
  assign pcsrcM      = branchM & zeroM;
  assign pc_branch_o = pc_branchM;

  assign isStore    = (memwriteM != ST_NONE);
  assign acc        = mem2regM | isStore;
  assign misal      = acc & isMisaligned(memwriteM, ldtypeM, a);
  assign accOk      = acc & ~misal;
  assign timeoutHit = accOk & (state == S_WAIT) & ~dmem_ready &
                      (cnt == CNT_W'(TIMEOUT - 1));
  assign done       = accOk & (dmem_ready | timeoutHit);
  assign loadDone   = accOk & mem2regM & ~isStore & dmem_ready;

  // Reset gates the request path so an in-flight access is abandoned at once.
  assign stallM    = accOk & ~done & ~clr;
  assign dmem_req  = accOk & ~clr;
  assign dmem_addr = {alu_outM[31:2], 2'b00};
  assign dmem_we   = (dmem_req & isStore) ? (memwriteM << a) : 4'b0000;

  always_comb begin
    case (memwriteM)
      ST_B:    dmem_wdata = {4{write_dataM[7:0]}};
      ST_H:    dmem_wdata = {2{write_dataM[15:0]}};
      default: dmem_wdata = write_dataM;
    endcase
  end

  minisys_load_align uLoadAlign (
    .rdata  (dmem_rdata),
    .ldtype (ldtypeM),
    .a      (a),
    .data   (loadData)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accOk && !dmem_ready) state <= S_WAIT;
        end
        default: begin
          if (done || !accOk) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      regwriteW  <= 1'b0;
      mem2regW   <= 1'b0;
      read_dataW <= '0;
      alu_outW   <= '0;
      write_regW <= '0;
      misalignW  <= 1'b0;
      bus_errW   <= 1'b0;
    end else if (stallM) begin
      regwriteW  <= 1'b0;
      mem2regW   <= 1'b0;
      read_dataW <= '0;
      alu_outW   <= '0;
      write_regW <= '0;
      misalignW  <= 1'b0;
      bus_errW   <= 1'b0;
    end else begin
      regwriteW  <= regwriteM & ~misal & ~timeoutHit;
      mem2regW   <= mem2regM;
      read_dataW <= loadDone ? loadData : 32'd0;
      alu_outW   <= alu_outM;
      write_regW <= write_regM;
      misalignW  <= misal;
      bus_errW   <= timeoutHit;
    end
  end

endmodule

// File: tb/tb_minisys_mem_stage.sv
// Directed bench for minisys_mem_stage: stores, loads, misalignment,
// timeout abort and asynchronous reset in the middle of a wait.
module tb_minisys_mem_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        regwriteM, mem2regM, branchM, zeroM;
  logic [3:0]  memwriteM;
  logic [2:0]  ldtypeM;
  logic [31:0] alu_outM, write_dataM, pc_branchM;
  logic [4:0]  write_regM;
  logic        pcsrcM;
  logic [31:0] pc_branch_o;
  logic        stallM;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        regwriteW, mem2regW;
  logic [31:0] read_dataW, alu_outW;
  logic [4:0]  write_regW;
  logic        misalignW, bus_errW;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  minisys_mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .clr(clr),
    .regwriteM(regwriteM), .mem2regM(mem2regM), .branchM(branchM), .zeroM(zeroM),
    .memwriteM(memwriteM), .ldtypeM(ldtypeM), .alu_outM(alu_outM),
    .write_dataM(write_dataM), .write_regM(write_regM), .pc_branchM(pc_branchM),
    .pcsrcM(pcsrcM), .pc_branch_o(pc_branch_o), .stallM(stallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .regwriteW(regwriteW), .mem2regW(mem2regW), .read_dataW(read_dataW),
    .alu_outW(alu_outW), .write_regW(write_regW),
    .misalignW(misalignW), .bus_errW(bus_errW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [3:0] mw,
                       input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    regwriteM   = rw;
    mem2regM    = m2r;
    memwriteM   = mw;
    ldtypeM     = lt;
    alu_outM    = alu;
    write_dataM = wd;
    write_regM  = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    clr = 1'b1;
    branchM = 1'b0; zeroM = 1'b0; pc_branchM = 32'h0;
    dmem_rdata = 32'h0; dmem_ready = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 3'b000, 32'h0, 32'h0, 5'd0);
    step(); step();
    check("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    check("rst_alu_outW", alu_outW, 32'd0);
    check("rst_stallM", {31'd0, stallM}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    #3 clr = 1'b0;
    step();

    // sw, zero-wait
    drive(1'b0, 1'b0, 4'b1111, 3'b000, 32'h100, 32'hDEADBEEF, 5'd0);
    dmem_ready = 1'b1;
    #1;
    check("sw_req", {31'd0, dmem_req}, 32'd1);
    check("sw_we", {28'd0, dmem_we}, 32'hF);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_stall", {31'd0, stallM}, 32'd0);
    step();
    check("sw_regwriteW", {31'd0, regwriteW}, 32'd0);
    check("sw_alu_outW", alu_outW, 32'h100);

    // sb at byte 3
    drive(1'b0, 1'b0, 4'b0001, 3'b000, 32'h203, 32'h000000A5, 5'd0);
    #1;
    check("sb_we", {28'd0, dmem_we}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("sb_addr", dmem_addr, 32'h200);
    step();

    // lb with 3 wait cycles
    drive(1'b1, 1'b1, 4'b0000, 3'b001, 32'h301, 32'h0, 5'd7);
    dmem_rdata = 32'h12348056;
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", {31'd0, stallM}, 32'd1);
      check("lb_req", {31'd0, dmem_req}, 32'd1);
      step();
      check("lb_bubble_rw", {31'd0, regwriteW}, 32'd0);
      check("lb_bubble_m2r", {31'd0, mem2regW}, 32'd0);
    end
    dmem_ready = 1'b1;
    #1;
    check("lb_done_stall", {31'd0, stallM}, 32'd0);
    step();
    check("lb_read_dataW", read_dataW, 32'hFFFFFF80);
    check("lb_mem2regW", {31'd0, mem2regW}, 32'd1);
    check("lb_regwriteW", {31'd0, regwriteW}, 32'd1);
    check("lb_write_regW", {27'd0, write_regW}, 32'd7);

    // lhu upper half
    drive(1'b1, 1'b1, 4'b0000, 3'b100, 32'h402, 32'h0, 5'd8);
    dmem_rdata = 32'hBEEF0000;
    step();
    check("lhu_read_dataW", read_dataW, 32'h0000BEEF);
    check("lhu_misalignW", {31'd0, misalignW}, 32'd0);

    // misaligned lw
    drive(1'b1, 1'b1, 4'b0000, 3'b000, 32'h402, 32'h0, 5'd9);
    #1;
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_stall", {31'd0, stallM}, 32'd0);
    step();
    check("mis_misalignW", {31'd0, misalignW}, 32'd1);
    check("mis_regwriteW", {31'd0, regwriteW}, 32'd0);

    // non-access ALU instruction
    drive(1'b1, 1'b0, 4'b0000, 3'b000, 32'h55, 32'h0, 5'd3);
    step();
    check("alu_alu_outW", alu_outW, 32'h55);
    check("alu_read_dataW", read_dataW, 32'd0);
    check("alu_regwriteW", {31'd0, regwriteW}, 32'd1);

    // timeout abort
    drive(1'b1, 1'b1, 4'b0000, 3'b000, 32'h500, 32'h0, 5'd4);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_stall", {31'd0, stallM}, 32'd1);
      step();
    end
    #1;
    check("to_abort_stall", {31'd0, stallM}, 32'd0);
    step();
    check("to_bus_errW", {31'd0, bus_errW}, 32'd1);
    check("to_regwriteW", {31'd0, regwriteW}, 32'd0);
    drive(1'b0, 1'b0, 4'b0000, 3'b000, 32'h0, 32'h0, 5'd0);
    #1;
    check("to_req_low", {31'd0, dmem_req}, 32'd0);
    step();
    check("to_bus_err_clear", {31'd0, bus_errW}, 32'd0);

    // reset in the middle of a wait
    branchM = 1'b1; zeroM = 1'b1; pc_branchM = 32'hCAFE0000;
    drive(1'b1, 1'b1, 4'b0000, 3'b000, 32'h600, 32'h0, 5'd5);
    step();
    step();
    check("rw_stall_pre", {31'd0, stallM}, 32'd1);
    check("rw_pcsrc_pre", {31'd0, pcsrcM}, 32'd1);
    clr = 1'b1;
    #1;
    check("rw_req", {31'd0, dmem_req}, 32'd0);
    check("rw_stall", {31'd0, stallM}, 32'd0);
    check("rw_regwriteW", {31'd0, regwriteW}, 32'd0);
    check("rw_read_dataW", read_dataW, 32'd0);
    check("rw_pcsrc", {31'd0, pcsrcM}, 32'd1);
    check("rw_pc_branch", pc_branch_o, 32'hCAFE0000);
    #1 clr = 1'b0;
    #1;
    check("rw_restart_stall", {31'd0, stallM}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rw_wait_stall", {31'd0, stallM}, 32'd1);
    end
    step();
    check("rw_abort_stall", {31'd0, stallM}, 32'd0);
    check("rw_pc_branch_end", pc_branch_o, 32'hCAFE0000);
    step();
    check("rw_bus_errW", {31'd0, bus_errW}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
